phys_mem_port: RTL and testbench
================================

Name: phys_mem_port

Overview:
- Physical memory stage directly downstream of the memory controller.
- Consumes the controller's physical request bus (phRamAddress, phRamOut, phReadReq, phWriteReq) and returns phRamIn.
- Backs that bus with an on-chip single-port word RAM. A secondary DMA port gets the RAM only on cycles the controller leaves idle.
- Guarantees the fixed read latency the controller depends on: data is valid on phRamIn one clock after the request is sampled, so the controller's two-state wait always sees it.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words.
- STARVE_LIMIT, 16, consecutive refused DMA cycles before dmaStarved asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- phRamAddress  in  32  byte address from memory controller.
- phRamOut  in  32  write data from memory controller.
- phReadReq  in  1  controller read request (level).
- phWriteReq  in  1  controller write request (level).
- phRamIn  out  32  read data to controller.
- dmaReqValid  in  1  DMA request valid.
- dmaReqReady  out  1  DMA request accepted this cycle.
- dmaReqWrite  in  1  1 = write, 0 = read.
- dmaReqAddr  in  32  DMA byte address.
- dmaReqData  in  32  DMA write data.
- dmaRespValid  out  1  one-cycle pulse, DMA read data valid.
- dmaRespData  out  32  DMA read data.
- initDone  out  1  RAM clear complete.
- addrError  out  1  sticky: an out-of-range address was seen.
- dmaStarved  out  1  DMA refused STARVE_LIMIT consecutive cycles.

Behaviour:
- Reset values (async, reset low): phRamIn=0, dmaReqReady=0, dmaRespValid=0, dmaRespData=0, initDone=0, addrError=0, dmaStarved=0, starve counter=0, init pointer=0, state=INIT. RAM contents are not touched by reset itself.
- Address decode: word index = addr[ADDR_WIDTH+1:2]. addr[1:0] are ignored (no misalignment fault).
- Out of range means any of addr[31:ADDR_WIDTH+2] is nonzero. For such an address: no RAM write; read returns 32'h0; addrError sets and stays set until reset.

State machine:
- INIT: writes 0 to word[ptr] each cycle and increments ptr. dmaReqReady=0. Controller requests are ignored and phRamIn holds 0. When ptr = 2^ADDR_WIDTH-1 is written, the next state is RUN and initDone=1 (registered).
- RUN: per-cycle arbitration; the controller has absolute priority.
  - mcAct = phReadReq | phWriteReq.
  - If mcAct, the controller owns the cycle.
  - If mcAct=0 and dmaReqValid=1, DMA owns the cycle.
  - Otherwise the RAM is idle.
- There are no other states. Reset asserted mid-INIT or mid-RUN returns to INIT with the pointer at 0.

Controller port (RUN):
- Requests are levels and are re-executed every cycle they are high. Repeated identical writes are harmless.
- Read: phRamIn <= word[idx] at the sampling edge, giving 1-cycle latency. phRamIn holds its value until the next controller read.
- Write: word[idx] <= phRamOut.
- Read and write both high: read-before-write. phRamIn gets the old word and the RAM gets phRamOut.

DMA port (RUN):
- dmaReqReady is combinational: state==RUN && !mcAct. A transfer occurs when dmaReqValid && dmaReqReady.
- Write: word updated, no response.
- Read: dmaRespData <= word[idx] and dmaRespValid=1 for exactly the next cycle. dmaRespData then holds.
- A DMA read never changes phRamIn, and a controller read never changes dmaRespData.

Starvation:
- The counter increments on each cycle with dmaReqValid && !dmaReqReady, saturating at STARVE_LIMIT.
- It clears on a DMA transfer or when dmaReqValid=0.
- dmaStarved = (counter == STARVE_LIMIT). This is a flag only; controller priority is never broken.

Optional Feature:
- Macro PHYS_MEM_PORT_STATS_EN.
- When defined, add outputs mcAccessCount[31:0], dmaAccessCount[31:0] and stallCount[31:0].
  - Counts are: controller-owned cycles, DMA transfers, and cycles the starve counter incremented.
  - All reset to 0, increment in RUN only, and wrap at 2^32.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Init clear: release reset, wait 2^ADDR_WIDTH cycles -> initDone=1 exactly one cycle after the last clear write; controller read of 0x0000_0010 -> phRamIn=0.
- Controller write/read: write 0xCAFE_F00D to 0x0000_0104 for one cycle, then read 0x0000_0107 -> phRamIn=0xCAFE_F00D one edge after the read is sampled; addr[1:0] ignored.
- Read-before-write: word[5]=0x11, then phReadReq=phWriteReq=1, addr 0x14, data 0x22 -> phRamIn=0x11; next read -> 0x22.
- Arbitration: DMA write 0xAA at 0x40 valid while controller reads for 3 cycles -> dmaReqReady=0 those cycles, DMA write accepted on the first idle cycle; DMA read of 0x40 -> dmaRespValid pulse with 0xAA; phRamIn unchanged.
- Starvation: hold dmaReqValid=1 with controller busy 20 cycles, STARVE_LIMIT=16 -> dmaStarved=1 from the 16th refused cycle and cleared after the accepted transfer.
- Range/reset: controller write to 0x0010_0000 -> RAM unchanged, addrError=1 sticky; assert reset mid-run -> all outputs at reset values, INIT restarts and RAM reads 0 afterwards.

Source files
------------

// File: rtl/phys_mem_port.sv
// Physical memory stage: single-port word RAM shared by the memory controller (priority) and a DMA port.
// Optional access statistics outputs are enabled by defining PHYS_MEM_PORT_STATS_EN.
module phys_mem_port #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] phRamAddress,
  input  logic [31:0] phRamOut,
  input  logic        phReadReq,
  input  logic        phWriteReq,
  output logic [31:0] phRamIn,
  input  logic        dmaReqValid,
  output logic        dmaReqReady,
  input  logic        dmaReqWrite,
  input  logic [31:0] dmaReqAddr,
  input  logic [31:0] dmaReqData,
  output logic        dmaRespValid,
  output logic [31:0] dmaRespData,
  output logic        initDone,
  output logic        addrError,
  output logic        dmaStarved
`ifdef PHYS_MEM_PORT_STATS_EN
  ,
  output logic [31:0] mcAccessCount,
  output logic [31:0] dmaAccessCount,
  output logic [31:0] stallCount
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int HI_W  = 32 - (ADDR_WIDTH + 2);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_MAX  = STARVE_LIMIT[CNT_W-1:0];

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Any set bit above the word index means the address lies outside the RAM.
  function automatic logic addr_out_of_range(input logic [HI_W-1:0] hi);
    return |hi;
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   init_ptr_r;
  logic [31:0]             mem_r [DEPTH];
  logic [CNT_W-1:0]        starve_cnt_r;
  logic [CNT_W-1:0]        starve_nxt_s;
  logic                    starve_inc_s;

  logic                    run_s;
  logic                    mc_act_s;
  logic                    mc_own_s;
  logic                    dma_ready_s;
  logic                    dma_xfer_s;
  logic                    mc_oor_s;
  logic                    dma_oor_s;
  logic [ADDR_WIDTH-1:0]   mc_idx_s;
  logic [ADDR_WIDTH-1:0]   dma_idx_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_s;
  logic                    ram_we_s;
  logic [31:0]             ram_wdata_s;
  logic [31:0]             ram_rdata_s;
  logic                    unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^{phRamAddress[1:0], dmaReqAddr[1:0]};

  assign run_s       = (state_r == ST_RUN);
  assign mc_act_s    = phReadReq | phWriteReq;
  assign mc_own_s    = run_s & mc_act_s;
  assign dma_ready_s = run_s & ~mc_act_s;
  assign dma_xfer_s  = dmaReqValid & dma_ready_s;
  assign dmaReqReady = dma_ready_s;

  assign mc_idx_s  = phRamAddress[ADDR_WIDTH+1:2];
  assign dma_idx_s = dmaReqAddr[ADDR_WIDTH+1:2];
  assign mc_oor_s  = addr_out_of_range(phRamAddress[31:ADDR_WIDTH+2]);
  assign dma_oor_s = addr_out_of_range(dmaReqAddr[31:ADDR_WIDTH+2]);

  // Single RAM port: init sweep, then controller, then DMA, in that order of ownership.
  always_comb begin
    ram_addr_s  = init_ptr_r;
    ram_we_s    = 1'b0;
    ram_wdata_s = 32'h0000_0000;
    if (!run_s) begin
      ram_we_s = 1'b1;
    end else if (mc_act_s) begin
      ram_addr_s  = mc_idx_s;
      ram_we_s    = phWriteReq & ~mc_oor_s;
      ram_wdata_s = phRamOut;
    end else if (dma_xfer_s) begin
      ram_addr_s  = dma_idx_s;
      ram_we_s    = dmaReqWrite & ~dma_oor_s;
      ram_wdata_s = dmaReqData;
    end else begin
      ram_addr_s = dma_idx_s;
    end
  end

  // Old word is read before the write lands, giving read-before-write on a combined request.
  assign ram_rdata_s = mem_r[ram_addr_s];

  // RAM storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_addr_s] <= ram_wdata_s;
    end
  end

  // Next-state logic: INIT leaves once the last word has been cleared.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_ptr_r == PTR_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Starve counter next value: saturating count of refused DMA cycles.
  always_comb begin
    starve_nxt_s = {CNT_W{1'b0}};
    starve_inc_s = 1'b0;
    if (dmaReqValid && !dma_ready_s) begin
      if (starve_cnt_r == CNT_MAX) begin
        starve_nxt_s = starve_cnt_r;
      end else begin
        starve_nxt_s = starve_cnt_r + CNT_ONE;
        starve_inc_s = 1'b1;
      end
    end else begin
      starve_nxt_s = {CNT_W{1'b0}};
    end
  end

  // State register, init pointer and init-complete flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_INIT;
      init_ptr_r <= {ADDR_WIDTH{1'b0}};
      initDone   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (!run_s) begin
        init_ptr_r <= init_ptr_r + PTR_ONE;
        if (init_ptr_r == PTR_LAST) begin
          initDone <= 1'b1;
        end
      end
    end
  end

  // Registered read data for both ports; each holds until its own next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phRamIn      <= 32'h0000_0000;
      dmaRespValid <= 1'b0;
      dmaRespData  <= 32'h0000_0000;
    end else begin
      if (mc_own_s && phReadReq) begin
        phRamIn <= mc_oor_s ? 32'h0000_0000 : ram_rdata_s;
      end
      dmaRespValid <= dma_xfer_s & ~dmaReqWrite;
      if (dma_xfer_s && !dmaReqWrite) begin
        dmaRespData <= dma_oor_s ? 32'h0000_0000 : ram_rdata_s;
      end
    end
  end

  // Sticky range error, starve counter and starved flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrError    <= 1'b0;
      starve_cnt_r <= {CNT_W{1'b0}};
      dmaStarved   <= 1'b0;
    end else begin
      if ((mc_own_s && mc_oor_s) || (dma_xfer_s && dma_oor_s)) begin
        addrError <= 1'b1;
      end
      starve_cnt_r <= starve_nxt_s;
      dmaStarved   <= (starve_nxt_s == CNT_MAX);
    end
  end

`ifdef PHYS_MEM_PORT_STATS_EN
  // Free-running statistics, advancing only while the port is in service.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcAccessCount  <= 32'h0000_0000;
      dmaAccessCount <= 32'h0000_0000;
      stallCount     <= 32'h0000_0000;
    end else begin
      if (mc_own_s) begin
        mcAccessCount <= mcAccessCount + 32'd1;
      end
      if (dma_xfer_s) begin
        dmaAccessCount <= dmaAccessCount + 32'd1;
      end
      if (run_s && starve_inc_s) begin
        stallCount <= stallCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_phys_mem_port.sv
// Self-checking bench for phys_mem_port: directed scenarios plus randomized traffic against a behavioural model.
module tb_phys_mem_port;

  localparam int DEPTH = 1024;
  localparam int LIM   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] phRamAddress, phRamOut, phRamIn;
  logic        phReadReq, phWriteReq;
  logic        dmaReqValid, dmaReqReady, dmaReqWrite;
  logic [31:0] dmaReqAddr, dmaReqData, dmaRespData;
  logic        dmaRespValid, initDone, addrError, dmaStarved;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  int          m_init_edges;
  logic [31:0] m_ph, m_resp_data;
  bit          m_resp_valid, m_err, m_init_done;
  int          m_starve;

  always #5 clk = ~clk;

  phys_mem_port #(.ADDR_WIDTH(10), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .phRamAddress(phRamAddress), .phRamOut(phRamOut),
    .phReadReq(phReadReq), .phWriteReq(phWriteReq), .phRamIn(phRamIn),
    .dmaReqValid(dmaReqValid), .dmaReqReady(dmaReqReady), .dmaReqWrite(dmaReqWrite),
    .dmaReqAddr(dmaReqAddr), .dmaReqData(dmaReqData),
    .dmaRespValid(dmaRespValid), .dmaRespData(dmaRespData),
    .initDone(initDone), .addrError(addrError), .dmaStarved(dmaStarved)
  );

  task automatic idle();
    phReadReq = 1'b0; phWriteReq = 1'b0; phRamAddress = 32'h0; phRamOut = 32'h0;
    dmaReqValid = 1'b0; dmaReqWrite = 1'b0; dmaReqAddr = 32'h0; dmaReqData = 32'h0;
  endtask

  // Advance the model by one clock edge from the current inputs, then step past the edge.
  task automatic tick();
    bit mc, rdy, moor, door;
    int unsigned midx, didx;
    mc   = phReadReq || phWriteReq;
    rdy  = m_run && !mc;
    midx = (phRamAddress >> 2) % DEPTH;
    didx = (dmaReqAddr >> 2) % DEPTH;
    moor = phRamAddress >= 32'(4 * DEPTH);
    door = dmaReqAddr >= 32'(4 * DEPTH);
    m_resp_valid = 1'b0;
    if (!m_run) begin
      m_init_edges++;
      if (m_init_edges == DEPTH) begin
        m_run = 1'b1;
        m_init_done = 1'b1;
        foreach (m_mem[i]) m_mem[i] = 32'h0;
      end
    end else if (mc) begin
      if (moor) m_err = 1'b1;
      if (phReadReq) m_ph = moor ? 32'h0 : m_mem[midx];
      if (phWriteReq && !moor) m_mem[midx] = phRamOut;
    end else if (dmaReqValid) begin
      if (door) m_err = 1'b1;
      if (dmaReqWrite) begin
        if (!door) m_mem[didx] = dmaReqData;
      end else begin
        m_resp_valid = 1'b1;
        m_resp_data  = door ? 32'h0 : m_mem[didx];
      end
    end
    if (dmaReqValid && !rdy) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
    else m_starve = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #2;
    checks++; if (phRamIn !== 32'h0)    begin errors++; $display("FAIL reset_phRamIn got %h want 0", phRamIn); end
    checks++; if (dmaReqReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", dmaReqReady); end
    checks++; if (dmaRespValid !== 1'b0) begin errors++; $display("FAIL reset_respValid got %b want 0", dmaRespValid); end
    checks++; if (dmaRespData !== 32'h0) begin errors++; $display("FAIL reset_respData got %h want 0", dmaRespData); end
    checks++; if (initDone !== 1'b0)    begin errors++; $display("FAIL reset_initDone got %b want 0", initDone); end
    checks++; if (addrError !== 1'b0)   begin errors++; $display("FAIL reset_addrError got %b want 0", addrError); end
    checks++; if (dmaStarved !== 1'b0)  begin errors++; $display("FAIL reset_starved got %b want 0", dmaStarved); end
    m_run = 1'b0; m_init_edges = 0; m_ph = 32'h0; m_resp_data = 32'h0;
    m_resp_valid = 1'b0; m_err = 1'b0; m_init_done = 1'b0; m_starve = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_init();
    for (int i = 0; i < DEPTH - 1; i++) tick();
    checks++; if (initDone !== 1'b0) begin errors++; $display("FAIL init_early got %b want 0", initDone); end
    checks++; if (dmaReqReady !== 1'b0) begin errors++; $display("FAIL init_ready got %b want 0", dmaReqReady); end
    tick();
    checks++; if (initDone !== 1'b1) begin errors++; $display("FAIL init_done got %b want 1", initDone); end
    phReadReq = 1'b1; phRamAddress = 32'h0000_0010;
    tick();
    idle();
    checks++; if (phRamIn !== 32'h0) begin errors++; $display("FAIL init_read got %h want 0", phRamIn); end
  endtask

  task automatic test_mc_rw();
    phWriteReq = 1'b1; phRamAddress = 32'h0000_0104; phRamOut = 32'hCAFE_F00D;
    tick();
    idle();
    phReadReq = 1'b1; phRamAddress = 32'h0000_0107;
    tick();
    idle();
    checks++; if (phRamIn !== 32'hCAFE_F00D) begin errors++; $display("FAIL mc_rw got %h want cafef00d", phRamIn); end
  endtask

  task automatic test_rbw();
    phWriteReq = 1'b1; phRamAddress = 32'h0000_0014; phRamOut = 32'h0000_0011;
    tick();
    phReadReq = 1'b1; phWriteReq = 1'b1; phRamOut = 32'h0000_0022;
    tick();
    checks++; if (phRamIn !== 32'h0000_0011) begin errors++; $display("FAIL rbw_old got %h want 11", phRamIn); end
    phWriteReq = 1'b0;
    tick();
    idle();
    checks++; if (phRamIn !== 32'h0000_0022) begin errors++; $display("FAIL rbw_new got %h want 22", phRamIn); end
  endtask

  task automatic test_arbitration();
    phReadReq = 1'b1; phRamAddress = 32'h0000_0104;
    dmaReqValid = 1'b1; dmaReqWrite = 1'b1; dmaReqAddr = 32'h0000_0040; dmaReqData = 32'h0000_00AA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dmaReqReady !== 1'b0) begin errors++; $display("FAIL arb_refused%0d got %b want 0", i, dmaReqReady); end
      tick();
    end
    phReadReq = 1'b0;
    #1;
    checks++; if (dmaReqReady !== 1'b1) begin errors++; $display("FAIL arb_idle_ready got %b want 1", dmaReqReady); end
    tick();
    dmaReqWrite = 1'b0;
    tick();
    idle();
    checks++; if (dmaRespValid !== 1'b1) begin errors++; $display("FAIL arb_resp_valid got %b want 1", dmaRespValid); end
    checks++; if (dmaRespData !== 32'h0000_00AA) begin errors++; $display("FAIL arb_resp_data got %h want aa", dmaRespData); end
    checks++; if (phRamIn !== 32'hCAFE_F00D) begin errors++; $display("FAIL arb_phRamIn got %h want cafef00d", phRamIn); end
    tick();
    checks++; if (dmaRespValid !== 1'b0) begin errors++; $display("FAIL arb_pulse_end got %b want 0", dmaRespValid); end
    checks++; if (dmaRespData !== 32'h0000_00AA) begin errors++; $display("FAIL arb_resp_hold got %h want aa", dmaRespData); end
  endtask

  task automatic test_starve();
    phReadReq = 1'b1; phRamAddress = 32'h0000_0000;
    dmaReqValid = 1'b1; dmaReqWrite = 1'b0; dmaReqAddr = 32'h0000_0040;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (dmaStarved !== (k >= LIM)) begin
        errors++; $display("FAIL starve_cycle%0d got %b want %b", k, dmaStarved, (k >= LIM));
      end
    end
    phReadReq = 1'b0;
    tick();
    idle();
    checks++; if (dmaStarved !== 1'b0) begin errors++; $display("FAIL starve_clear got %b want 0", dmaStarved); end
    checks++; if (dmaRespData !== 32'h0000_00AA) begin errors++; $display("FAIL starve_xfer got %h want aa", dmaRespData); end
  endtask

  task automatic test_range();
    phWriteReq = 1'b1; phRamAddress = 32'h0010_0000; phRamOut = 32'hDEAD_BEEF;
    tick();
    idle();
    checks++; if (addrError !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", addrError); end
    phReadReq = 1'b1; phRamAddress = 32'h0000_0000;
    tick();
    checks++; if (phRamIn !== 32'h0) begin errors++; $display("FAIL range_alias got %h want 0", phRamIn); end
    phRamAddress = 32'h0000_0104;
    tick();
    phRamAddress = 32'h0010_0104;
    tick();
    idle();
    checks++; if (phRamIn !== 32'h0) begin errors++; $display("FAIL range_read got %h want 0", phRamIn); end
    tick(); tick();
    checks++; if (addrError !== 1'b1) begin errors++; $display("FAIL range_sticky got %b want 1", addrError); end
  endtask

  task automatic test_random();
    bit busy_phase;
    for (int c = 0; c < 600; c++) begin
      busy_phase = (c % 100) < 40;
      phReadReq    = busy_phase ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      phWriteReq   = ($urandom_range(0, 3) == 0);
      phRamAddress = (($urandom_range(0, 15) == 0) ? 32'h0000_1000 : 32'h0) | 32'($urandom_range(0, 63));
      phRamOut     = $urandom;
      dmaReqValid  = busy_phase ? 1'b1 : ($urandom_range(0, 1) == 1);
      dmaReqWrite  = ($urandom_range(0, 1) == 1);
      dmaReqAddr   = (($urandom_range(0, 15) == 0) ? 32'h0020_0000 : 32'h0) | 32'($urandom_range(0, 63));
      dmaReqData   = $urandom;
      #1;
      checks++;
      if (dmaReqReady !== (m_run && !(phReadReq || phWriteReq))) begin
        errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, dmaReqReady, (m_run && !(phReadReq || phWriteReq)));
      end
      tick();
      checks++;
      if (phRamIn !== m_ph) begin errors++; $display("FAIL rnd_phRamIn c%0d got %h want %h", c, phRamIn, m_ph); end
      checks++;
      if (dmaRespValid !== m_resp_valid) begin errors++; $display("FAIL rnd_respValid c%0d got %b want %b", c, dmaRespValid, m_resp_valid); end
      checks++;
      if (dmaRespData !== m_resp_data) begin errors++; $display("FAIL rnd_respData c%0d got %h want %h", c, dmaRespData, m_resp_data); end
      checks++;
      if (dmaStarved !== (m_starve == LIM)) begin errors++; $display("FAIL rnd_starved c%0d got %b want %b", c, dmaStarved, (m_starve == LIM)); end
      checks++;
      if (addrError !== m_err) begin errors++; $display("FAIL rnd_addrError c%0d got %b want %b", c, addrError, m_err); end
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    phWriteReq = 1'b1; phRamAddress = 32'h0000_0020; phRamOut = 32'h1234_5678;
    tick();
    idle();
    test_reset();
    checks++; if (initDone !== 1'b0) begin errors++; $display("FAIL midrst_initDone got %b want 0", initDone); end
    for (int i = 0; i < DEPTH; i++) tick();
    checks++; if (initDone !== 1'b1) begin errors++; $display("FAIL midrst_reinit got %b want 1", initDone); end
    checks++; if (addrError !== 1'b0) begin errors++; $display("FAIL midrst_addrError got %b want 0", addrError); end
    phReadReq = 1'b1; phRamAddress = 32'h0000_0020;
    tick();
    idle();
    checks++; if (phRamIn !== 32'h0) begin errors++; $display("FAIL midrst_cleared got %h want 0", phRamIn); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_mc_rw();
    test_rbw();
    test_arbitration();
    test_starve();
    test_range();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
